// File: rtl/present80_decrypt.sv
// Iterative PRESENT-80 decryptor: derives the last round key with the forward schedule,
// then peels off 31 rounds (one per clock) and holds the plaintext behind valid/ready.
module present80_decrypt (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ciphertext,
    input  logic [79:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plaintext,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYFWD = 2'd1,
        DEC    = 2'd2,
        DONE   = 2'd3
    } fsm_t;

    fsm_t        fsm_r;
    logic [63:0] state_r;
    logic [79:0] kreg_r;
    logic [4:0]  rc_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        busy_r;

    logic [63:0] dec_state_s;
    logic [79:0] kfwd_s;
    logic [79:0] kinv_s;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'hC;
            4'h1:    y = 4'h5;
            4'h2:    y = 4'h6;
            4'h3:    y = 4'hB;
            4'h4:    y = 4'h9;
            4'h5:    y = 4'h0;
            4'h6:    y = 4'hA;
            4'h7:    y = 4'hD;
            4'h8:    y = 4'h3;
            4'h9:    y = 4'hE;
            4'hA:    y = 4'hF;
            4'hB:    y = 4'h8;
            4'hC:    y = 4'h4;
            4'hD:    y = 4'h7;
            4'hE:    y = 4'h1;
            4'hF:    y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'h5;
            4'h1:    y = 4'hE;
            4'h2:    y = 4'hF;
            4'h3:    y = 4'h8;
            4'h4:    y = 4'hC;
            4'h5:    y = 4'h1;
            4'h6:    y = 4'h2;
            4'h7:    y = 4'hD;
            4'h8:    y = 4'hB;
            4'h9:    y = 4'h4;
            4'hA:    y = 4'h6;
            4'hB:    y = 4'h3;
            4'hC:    y = 4'h0;
            4'hD:    y = 4'h7;
            4'hE:    y = 4'h9;
            4'hF:    y = 4'hA;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // Forward pLayer sends bit i to (16*i) mod 63, so the inverse gathers from there.
    function automatic logic [63:0] inv_player(input logic [63:0] x);
        logic [63:0] y;
        logic [5:0]  src;
        y = 64'd0;
        for (int i = 0; i < 63; i++) begin
            src  = 6'((16 * i) % 63);
            y[i] = x[src];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [63:0] inv_slayer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        for (int j = 0; j < 16; j++) begin
            y[4*j +: 4] = sbox_inv(x[4*j +: 4]);
        end
        return y;
    endfunction

    function automatic logic [79:0] fwd_update(input logic [79:0] k, input logic [4:0] c);
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ c;
        return t;
    endfunction

    // Exact inverse of fwd_update for the same counter value.
    function automatic logic [79:0] inv_update(input logic [79:0] k, input logic [4:0] c);
        logic [79:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ c;
        t[79:76]   = sbox_inv(t[79:76]);
        t          = {t[60:0], t[79:61]};
        return t;
    endfunction

    assign dec_state_s = inv_slayer(inv_player(state_r ^ kreg_r[79:16]));
    assign kfwd_s      = fwd_update(kreg_r, rc_r);
    assign kinv_s      = inv_update(kreg_r, rc_r);

    // Control FSM plus datapath registers; handshake flags are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r       <= IDLE;
            state_r     <= 64'd0;
            kreg_r      <= 80'd0;
            rc_r        <= 5'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (in_valid) begin
                        state_r    <= ciphertext;
                        kreg_r     <= key;
                        rc_r       <= 5'd1;
                        fsm_r      <= KEYFWD;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                KEYFWD: begin
                    kreg_r <= kfwd_s;
                    if (rc_r == 5'd31) begin
                        fsm_r <= DEC;
                    end else begin
                        rc_r <= rc_r + 5'd1;
                    end
                end
                DEC: begin
                    state_r <= dec_state_s;
                    kreg_r  <= kinv_s;
                    if (rc_r == 5'd1) begin
                        fsm_r       <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        rc_r <= rc_r - 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_r       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    fsm_r       <= IDLE;
                    state_r     <= 64'd0;
                    kreg_r      <= 80'd0;
                    rc_r        <= 5'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    // Final whitening with K1 is folded into the output path.
    assign plaintext = state_r ^ kreg_r[79:16];

endmodule
